// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI flash arbiter and its wake sequencer.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        StWakeCs    = 3'd0,
        StWakeShift = 3'd1,
        StWakeEnd   = 3'd2,
        StWaitRes   = 3'd3,
        StIdle      = 3'd4,
        StOwnA      = 3'd5,
        StOwnB      = 3'd6,
        StGuard     = 3'd7
    } arb_state_t;

    typedef enum logic {
        OwnerA = 1'b0,
        OwnerB = 1'b1
    } owner_t;

    // Release-from-deep-power-down opcode.
    localparam logic [7:0] WAKE_CMD_DEFAULT = 8'hAB;

    // Width of the shared down-counter covering every timed state.
    function automatic int unsigned cnt_width(input int unsigned clk_div,
                                              input int unsigned t_res,
                                              input int unsigned guard);
        int unsigned m;
        m = 16 * clk_div;
        if (t_res > m) m = t_res;
        if (guard > m) m = guard;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_flash_wake_seq.sv
// Wake-up sequencer: decodes the wake states and the shared counter into pad levels,
// the next wake state/count, and a done pulse on the last WAIT_RES cycle.
module spi_flash_wake_seq
    import spi_arb_pkg::*;
#(
    parameter logic [7:0]  WAKE_CMD     = WAKE_CMD_DEFAULT,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned T_RES_CYCLES = 48,
    parameter int unsigned CNT_W        = 6
) (
    input  logic [2:0]       state,
    input  logic [CNT_W-1:0] cnt,
    output logic [2:0]       next_state,
    output logic [CNT_W-1:0] next_cnt,
    output logic             cs_b,
    output logic             sck,
    output logic             mosi,
    output logic             done
);

    localparam int unsigned      BitCycles = 2 * CLK_DIV;
    localparam logic [CNT_W-1:0] ShiftLoad = CNT_W'(16 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] ResLoad   = CNT_W'(T_RES_CYCLES - 1);

    arb_state_t  st;
    arb_state_t  st_d;
    logic [31:0] cnt_ext;
    logic [2:0]  bit_idx;

    assign st         = arb_state_t'(state);
    assign next_state = st_d;
    assign cnt_ext    = 32'(cnt);
    // Counting down from 16*CLK_DIV-1 makes the quotient the MSB-first bit index.
    assign bit_idx    = 3'(cnt_ext / BitCycles);

    always_comb begin
        st_d     = st;
        next_cnt = cnt;
        cs_b     = 1'b1;
        sck      = 1'b1;
        mosi     = 1'b0;
        done     = 1'b0;
        case (st)
            StWakeCs: begin
                cs_b     = 1'b0;
                mosi     = WAKE_CMD[7];
                st_d     = StWakeShift;
                next_cnt = ShiftLoad;
            end
            StWakeShift: begin
                cs_b = 1'b0;
                // Upper half of each bit period is the low phase, lower half the high phase.
                sck  = (cnt_ext % BitCycles) < CLK_DIV;
                mosi = WAKE_CMD[bit_idx];
                if (cnt == '0) begin
                    st_d = StWakeEnd;
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            StWakeEnd: begin
                cs_b     = 1'b0;
                st_d     = StWaitRes;
                next_cnt = ResLoad;
            end
            StWaitRes: begin
                if (cnt == '0) begin
                    st_d = StIdle;
                    done = 1'b1;
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash between two masters: wakes the flash after reset, then grants the
// bus round-robin, never cutting a transaction, with a guard gap between owners.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter logic [7:0]  WAKE_CMD     = WAKE_CMD_DEFAULT,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned T_RES_CYCLES = 48,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt,
    input  logic a_cs_b,
    input  logic a_sck,
    input  logic a_mosi,
    output logic a_miso,
    input  logic b_cs_b,
    input  logic b_sck,
    input  logic b_mosi,
    output logic b_miso,
    output logic spi_cs_b,
    output logic spi_sck,
    output logic spi_mosi,
    input  logic spi_miso,
    output logic ready
);

    localparam int unsigned      CNT_W     = cnt_width(CLK_DIV, T_RES_CYCLES, GUARD_CYCLES);
    localparam logic [CNT_W-1:0] GuardLoad =
        (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    owner_t           last_q;
    owner_t           last_d;
    logic             ready_q;
    logic             ready_d;
    logic             a_gnt_q;
    logic             b_gnt_q;

    logic [2:0]       wake_next;
    logic [CNT_W-1:0] wake_cnt;
    logic             wake_cs_b;
    logic             wake_sck;
    logic             wake_mosi;
    logic             wake_done;

    logic             pad_cs_b;
    logic             pad_sck;
    logic             pad_mosi;

    spi_flash_wake_seq #(
        .WAKE_CMD     (WAKE_CMD),
        .CLK_DIV      (CLK_DIV),
        .T_RES_CYCLES (T_RES_CYCLES),
        .CNT_W        (CNT_W)
    ) u_wake_seq (
        .state      (state_q),
        .cnt        (cnt_q),
        .next_state (wake_next),
        .next_cnt   (wake_cnt),
        .cs_b       (wake_cs_b),
        .sck        (wake_sck),
        .mosi       (wake_mosi),
        .done       (wake_done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ready_d = ready_q;
        unique case (state_q)
            StWakeCs, StWakeShift, StWakeEnd, StWaitRes: begin
                state_d = arb_state_t'(wake_next);
                cnt_d   = wake_cnt;
                if (wake_done) begin
                    ready_d = 1'b1;
                end
            end
            StIdle: begin
                // On a tie the master that did not own the bus last wins.
                if (a_req && (!b_req || last_q == OwnerB)) begin
                    state_d = StOwnA;
                end else if (b_req) begin
                    state_d = StOwnB;
                end
            end
            StOwnA: begin
                if (!a_req && a_cs_b) begin
                    last_d  = OwnerA;
                    state_d = (GUARD_CYCLES > 0) ? StGuard : StIdle;
                    cnt_d   = GuardLoad;
                end
            end
            StOwnB: begin
                if (!b_req && b_cs_b) begin
                    last_d  = OwnerB;
                    state_d = (GUARD_CYCLES > 0) ? StGuard : StIdle;
                    cnt_d   = GuardLoad;
                end
            end
            StGuard: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StWakeCs;
            cnt_q   <= '0;
            last_q  <= OwnerB;
            ready_q <= 1'b0;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            a_gnt_q <= (state_d == StOwnA);
            b_gnt_q <= (state_d == StOwnB);
        end
    end

    always_comb begin
        pad_cs_b = wake_cs_b;
        pad_sck  = wake_sck;
        pad_mosi = wake_mosi;
        a_miso   = 1'b0;
        b_miso   = 1'b0;
        case (state_q)
            StOwnA: begin
                pad_cs_b = a_cs_b;
                pad_sck  = a_sck;
                pad_mosi = a_mosi;
                a_miso   = spi_miso;
            end
            StOwnB: begin
                pad_cs_b = b_cs_b;
                pad_sck  = b_sck;
                pad_mosi = b_mosi;
                b_miso   = spi_miso;
            end
            default: ;
        endcase
    end

    // Reset forces the pads idle in the same cycle, even though WAKE_CS is the reset state.
    assign spi_cs_b = pad_cs_b | ~reset;
    assign spi_sck  = pad_sck | ~reset;
    assign spi_mosi = pad_mosi & reset;

    assign a_gnt = a_gnt_q;
    assign b_gnt = b_gnt_q;
    assign ready = ready_q;

endmodule

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Shares the single physical SPI flash port between two SPI masters: port A (USB bridge, host-side flash access) and port B (user-side flash reader). After reset the block owns the bus, wakes the flash with a release-from-deep-power-down command, then grants the bus to one master at a time through a req/gnt handshake. A transaction in progress is never cut, and a guard gap separates owners. It sits between the masters' SPI pins and the top-level flash pads.

## Interface
- WAKE_CMD, 8'hAB: opcode shifted out after reset.
- CLK_DIV, 2: clk cycles per SCK half-period during the wake command (≥1).
- T_RES_CYCLES, 48: idle cycles after the wake command with CS high before the first grant (≥1).
- GUARD_CYCLES, 2: cycles with CS high between release and next arbitration (0 allowed).
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low.
- a_req, b_req  in  1  master requests bus.
- a_gnt, b_gnt  out  1  master owns bus; registered; at most one high.
- a_cs_b, a_sck, a_mosi  in  1  port A SPI drive.
- a_miso  out  1  flash MISO when A owns bus, else 0.
- b_cs_b, b_sck, b_mosi, b_miso: same for port B.
- spi_cs_b, spi_sck, spi_mosi  out  1  flash pads.
- spi_miso  in  1  flash pad.
- ready  out  1  wake sequence complete; stays high until reset.

## Operation
- States: WAKE_CS, WAKE_SHIFT, WAKE_END, WAIT_RES, IDLE, OWN_A, OWN_B, GUARD.
- Reset (asserted low): state WAKE_CS; spi_cs_b=1, spi_sck=1, spi_mosi=0, a_gnt=b_gnt=0, ready=0, a_miso=b_miso=0, last_owner=B. Reset mid-transaction aborts it immediately and restarts the wake sequence.
- WAKE_CS (1 cycle): cs_b=0, sck=1, mosi=WAKE_CMD[7].
- WAKE_SHIFT (16·CLK_DIV cycles): SPI mode 3, MSB first. For each bit, sck=0 for CLK_DIV cycles, then sck=1 for CLK_DIV cycles. mosi updates at the start of each low phase.
- WAKE_END (1 cycle): cs_b=0, sck=1.
- WAIT_RES (T_RES_CYCLES): cs_b=1. Then go to IDLE and set ready=1.
- IDLE: pads cs_b=1, sck=1, mosi=0.
  - Single request: grant that master.
  - Both requesting: grant the master that is not last_owner (round-robin), so A wins the first tie.
- OWN_x: spi_cs_b, spi_sck and spi_mosi are combinationally muxed from port x; x_miso=spi_miso; the other port's miso=0.
  - Leave only when x_req=0 and x_cs_b=1 in the same cycle. Go to GUARD if GUARD_CYCLES>0, else IDLE. Update last_owner=x.
  - If x_req drops while x_cs_b=0, ownership is held until x_cs_b rises.
- GUARD: pads idle, both gnt low for GUARD_CYCLES, then IDLE.
- Requests that arrive before ready are held and served at the first IDLE cycle.
- Counter width: $clog2(max(16·CLK_DIV, T_RES_CYCLES, GUARD_CYCLES)+1). One shared down-counter serves all timed states.

## Timing
- Wake latency with defaults: reset release → ready high on cycle 1+32+1+48 = 82.
- Grant latency: req high in IDLE at edge n → x_gnt high after edge n+1.
- Release: qualifying release at edge n → x_gnt low after n+1.
- Next grant: no earlier than GUARD_CYCLES+1 cycles after release.
- Pad mux is combinational: zero-cycle path from the owner's pins to the pads. Masters must not drive cs_b low before gnt.
- Non-owner pin activity has no effect on the pads.

## Structure
- Shared package (spi_arb_pkg): state encoding constants, default WAKE_CMD 8'hAB.
- Natural sub-module: spi_flash_wake_seq, which runs WAKE_CS through WAIT_RES and outputs cs_b/sck/mosi/done. The arbiter core and pad mux stay in the top module.

## Test plan
- Reset release, no requests → exactly 8 SCK rising edges, MOSI sampled on rising edges = 0xAB. CS is low during the shift, then high; ready rises on cycle 82.
- a_req held during wake → a_gnt high on the cycle after ready; b_gnt stays 0.
- a_req and b_req rise the same cycle in IDLE after reset → A granted. A releases; after a 2-cycle guard, B is granted. Tie again → A granted (round-robin).
- A owns the bus, drops a_req while a_cs_b=0 for 10 more cycles → a_gnt is held; pads follow A until a_cs_b=1, then release.
- B toggles b_cs_b/b_sck while A owns the bus → pads unaffected; b_miso=0; a_miso mirrors spi_miso.
- Reset asserted mid-OWN_A → same-cycle spi_cs_b=1, a_gnt=0. After release, the full wake sequence repeats.
